// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back bundle for mem_stage.
// The misalign flag only exists in builds with MEM_MISALIGN_TRAP_EN defined.
interface mem_stage_if;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    output in_valid, alu_result, store_data, rd, mem_read, mem_write, reg_write,
    input  stall, wb_valid, wb_data, wb_rd, wb_reg_write, misalign
  );
  modport slave (
    input  in_valid, alu_result, store_data, rd, mem_read, mem_write, reg_write,
    output stall, wb_valid, wb_data, wb_rd, wb_reg_write, misalign
  );
`else
  modport master (
    output in_valid, alu_result, store_data, rd, mem_read, mem_write, reg_write,
    input  stall, wb_valid, wb_data, wb_rd, wb_reg_write
  );
  modport slave (
    input  in_valid, alu_result, store_data, rd, mem_read, mem_write, reg_write,
    output stall, wb_valid, wb_data, wb_rd, wb_reg_write
  );
`endif
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word load/store on internal RAM with WAIT_STATES extra cycles.
// Optional build macro MEM_MISALIGN_TRAP_EN traps accesses with alu_result[1:0] != 0.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         ZERO_WS  = (WAIT_STATES == 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_op_q, rd_op_d;
  logic        wr_op_q, wr_op_d;
  logic        rw_q, rw_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem [DEPTH];

  logic        in_wait;
  logic [31:0] op_alu, op_sdata, rdata;
  logic [4:0]  op_rd;
  logic        op_read, op_write, op_rw;
  logic        is_mem, is_store, mis;
  logic        retire, mem_we;
  logic [AW-1:0] idx;

  // In IDLE the live inputs drive the access; in WAIT the latched copy does.
  assign in_wait  = (state_q == WAIT);
  assign op_alu   = in_wait ? alu_q   : bus.alu_result;
  assign op_sdata = in_wait ? sdata_q : bus.store_data;
  assign op_rd    = in_wait ? rd_q    : bus.rd;
  assign op_read  = in_wait ? rd_op_q : bus.mem_read;
  assign op_write = in_wait ? wr_op_q : bus.mem_write;
  assign op_rw    = in_wait ? rw_q    : bus.reg_write;

  assign is_mem   = op_read | op_write;
  assign is_store = op_write & ~op_read;
  assign idx      = op_alu[AW+1:2];
  assign rdata    = mem[idx];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem & (op_alu[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_d          = alu_q;
    sdata_d        = sdata_q;
    rd_d           = rd_q;
    rd_op_d        = rd_op_q;
    wr_op_d        = wr_op_q;
    rw_d           = rw_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    misalign_d     = 1'b0;
    retire         = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_mem && !ZERO_WS) begin
            alu_d   = bus.alu_result;
            sdata_d = bus.store_data;
            rd_d    = bus.rd;
            rd_op_d = bus.mem_read;
            wr_op_d = bus.mem_write;
            rw_d    = bus.reg_write;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end else begin
            retire = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      wb_valid_d     = 1'b1;
      wb_data_d      = op_read ? rdata : op_alu;
      wb_rd_d        = op_rd;
      wb_reg_write_d = op_rw & ~mis;
      misalign_d     = mis;
      mem_we         = is_store & ~mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      misalign_q     <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    alu_q   <= alu_d;
    sdata_q <= sdata_d;
    rd_q    <= rd_d;
    rd_op_q <= rd_op_d;
    wr_op_q <= wr_op_d;
    rw_q    <= rw_d;
  end

  // RAM is never reset; rst_n gating keeps a reset-time cycle from writing it.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[idx] <= op_sdata;
    end
  end

  assign bus.stall        = in_wait;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_reg_write = wb_reg_write_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.misalign     = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It takes the ALU result and store operand from execute, performs a word load or store on an internal data memory with a configurable number of wait states, and presents the write-back result to the WB stage. It stalls the upstream stages while a memory access is in flight.

## Interface

Parameters:
- `DEPTH`, 256: data memory size in 32-bit words. Must be a power of two.
- `WAIT_STATES`, 2: extra cycles per load or store. Range 0–15.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute stage presents an instruction.
- `alu_result` in 32: effective address for load/store, or the result for ALU ops.
- `store_data` in 32: rt operand for stores.
- `rd` in 5: destination register.
- `mem_read` in 1: load word.
- `mem_write` in 1: store word.
- `reg_write` in 1: instruction writes the register file.
- `stall` out 1: upstream must hold all `in_*` signals stable.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_data` out 32: load data, or `alu_result`.
- `wb_rd` out 5: destination register.
- `wb_reg_write` out 1: register-file write enable for WB.
- `misalign` out 1: misaligned-access flag. Only present in the `MEM_MISALIGN_TRAP_EN` build.

## Operation

- FSM states: IDLE, WAIT.
- **IDLE, `in_valid`=1, non-memory op** (`mem_read`=`mem_write`=0):
  - Next edge: `wb_valid`=1, `wb_data`=`alu_result`, `wb_rd`=`rd`, `wb_reg_write`=`reg_write`.
  - State remains IDLE.
- **IDLE, `in_valid`=1, memory op, `WAIT_STATES`=0:**
  - Access completes at that same edge; WB outputs update at that edge.
- **IDLE, `in_valid`=1, memory op, `WAIT_STATES`>0:**
  - Latch address, data, `rd`, and control.
  - Load counter with `WAIT_STATES`-1 and enter WAIT.
- **WAIT:**
  - Counter decrements each cycle.
  - When the counter reaches 0: commit the store (or read the word), drive WB outputs at the next edge, return to IDLE.
- `mem_read`=`mem_write`=1 together is treated as a load; no write occurs.
- **Stores:** `wb_reg_write` follows the input (the decoder drives 0). `wb_data`=`alu_result`.
- **Loads:** `wb_data`=mem[word index].
- **Address mapping:** word index = `alu_result[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses alias modulo DEPTH×4 bytes.
- Memory contents are not reset; initial contents are X.
- `in_valid`=0 in IDLE: `wb_valid`=0 next cycle; other WB outputs hold their last values.
- Inputs presented while `stall`=1 are not sampled.

## Timing

- **Reset values:** state IDLE, counter 0, `stall`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_reg_write`=0, `misalign`=0.
- `stall` is combinational: `stall` = (state==WAIT).
- **Latency, in → `wb_valid`:**
  - 1 cycle for ALU ops and memory ops with `WAIT_STATES`=0.
  - `WAIT_STATES`+1 cycles for memory ops otherwise.
  - `stall` is high for exactly `WAIT_STATES` cycles.
- **Throughput:** 1 instruction/cycle for back-to-back ALU ops. A new instruction is accepted in the cycle after WAIT exits (IDLE).
- **Read-after-write:** a load issued immediately after a store to the same address returns the new data, because the store commits before the load is accepted.
- **Reset mid-WAIT:** the pending store is dropped, with no memory write. `stall` falls immediately (asynchronously).

## Configuration

- `MEM_MISALIGN_TRAP_EN` defined:
  - A load or store with `alu_result[1:0]`≠0 suppresses the memory write.
  - `wb_reg_write` is forced to 0.
  - `misalign` pulses high together with that instruction's `wb_valid`.
  - Timing is unchanged.
- `MEM_MISALIGN_TRAP_EN` not defined:
  - `alu_result[1:0]` is ignored and the access uses the enclosing word.
  - The `misalign` port does not exist.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 and `stall`=0 within the same cycle, asynchronously.
- **ALU passthrough:** ALU op `alu_result`=0x0000_1234, `rd`=5, `reg_write`=1 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, `wb_reg_write`=1. Back-to-back ops retire with no stall.
- **Store then load, `WAIT_STATES`=2:** store 0xDEAD_BEEF to addr 0x10 → `stall` high for 2 cycles, `wb_valid` 3 cycles after issue. Then load addr 0x10 into `rd`=8 → `wb_data`=0xDEADBEEF, `wb_rd`=8.
- **Aliasing, `DEPTH`=256:** store 0x5A5A_5A5A to 0x404, then load 0x004 → returns 0x5A5A5A5A.
- **Reset during WAIT:** issue store 0x1111_1111 to 0x20, assert `rst_n` on cycle 1 of WAIT → `stall`=0. After release, load 0x20 does not return 0x11111111 (preload 0 first, so it returns 0).
- **Misalignment:**
  - With `MEM_MISALIGN_TRAP_EN`: store to 0x22 → `misalign`=1 with `wb_valid`, and mem[8] is unchanged.
  - Without the macro: load 0x22 → returns mem[8].
